// File: rtl/ctrl_protocol_monitor.sv
// Hardware scoreboard for the VeriRISC control bus: tracks the 8-phase cycle on its own,
// derives the expected control word and counts/captures mismatches and completed instructions.
module ctrl_protocol_monitor #(
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sync,
  input  logic [6:0]       ctrl_bus,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic [2:0]       phase,
  output logic [6:0]       expected,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [2:0]       first_err_phase,
  output logic [6:0]       first_err_is,
  output logic [6:0]       first_err_exp,
  output logic [CNT_W-1:0] instr_count,
  output logic             stopped
);

  localparam int unsigned PH_W  = 3;
  localparam int unsigned BUS_W = 7;

  typedef enum logic [PH_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  state_t             phase_q, phase_d;
  logic               mismatch_q, mismatch_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fv_q, fv_d;
  logic [PH_W-1:0]    fph_q, fph_d;
  logic [BUS_W-1:0]   fis_q, fis_d;
  logic [BUS_W-1:0]   fexp_q, fexp_d;
  logic [CNT_W-1:0]   instr_q, instr_d;

  opcode_t            op;
  logic               is_aluop;
  logic               mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
  logic               fail_c;
  logic               advance_c;

  assign op       = opcode_t'(opcode);
  assign is_aluop = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);

  // Expected control word for the tracked phase and current opcode/zero
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    case (phase_q)
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (op == HLT);
      end
      OP_FETCH: mem_rd = is_aluop;
      ALU_OP: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        inc_pc  = (op == SKZ) && zero;
        load_pc = (op == JMP);
      end
      STORE: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        inc_pc  = (op == JMP);
        load_pc = (op == JMP);
        mem_wr  = (op == STO);
      end
      default: ;
    endcase
  end

  assign expected = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};

  // Case inequality so any X/Z on the observed bus is reported as a failure
  assign fail_c    = (ctrl_bus !== expected);
  assign stopped   = STOP_ON_ERR & fv_q;
  assign advance_c = enable & ~sync & ~stopped;

  // Next-state: phase tracking, compare, counters and first-error capture
  always_comb begin
    phase_d    = phase_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    fv_d       = fv_q;
    fph_d      = fph_q;
    fis_d      = fis_q;
    fexp_d     = fexp_q;
    instr_d    = instr_q;
    if (sync) begin
      phase_d = INST_ADDR;
    end else if (advance_c) begin
      mismatch_d = fail_c;
      if (fail_c) begin
        if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
        if (!fv_q) begin
          fv_d   = 1'b1;
          fph_d  = phase_q;
          fis_d  = ctrl_bus;
          fexp_d = expected;
        end
      end
      // A stopping mismatch leaves phase pointing at the failing step
      if (!(fail_c && STOP_ON_ERR)) begin
        phase_d = state_t'(phase_q + PH_W'(1));
        if (phase_q == STORE && instr_q != {CNT_W{1'b1}}) instr_d = instr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= INST_ADDR;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      fv_q       <= 1'b0;
      fph_q      <= '0;
      fis_q      <= '0;
      fexp_q     <= '0;
      instr_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
      fph_q      <= fph_d;
      fis_q      <= fis_d;
      fexp_q     <= fexp_d;
      instr_q    <= instr_d;
    end
  end

  assign phase           = phase_q;
  assign mismatch        = mismatch_q;
  assign err_count       = err_q;
  assign first_err_valid = fv_q;
  assign first_err_phase = fph_q;
  assign first_err_is    = fis_q;
  assign first_err_exp   = fexp_q;
  assign instr_count     = instr_q;

endmodule

// File: tb/tb_ctrl_protocol_monitor.sv
// Bench for ctrl_protocol_monitor: three parameterisations share one stimulus stream and are
// checked against a rule-level reference model of phase, expected word, errors and counts.
module tb_ctrl_protocol_monitor;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, STO = 3'd6;

  logic       clk = 1'b0;
  logic       rs_r = 1'b1, en_r = 1'b0, sy_r = 1'b0, z_r = 1'b0;
  logic [2:0] op_r = 3'd2;
  logic [6:0] bus_r = 7'd0;

  logic [2:0]  ph_o   [3];
  logic [6:0]  exp_o  [3];
  logic        mis_o  [3];
  logic        fv_o   [3];
  logic [2:0]  fph_o  [3];
  logic [6:0]  fis_o  [3];
  logic [6:0]  fexp_o [3];
  logic [15:0] ic_o   [3];
  logic        st_o   [3];
  logic [7:0]  err0, err1;
  logic [1:0]  err2;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: 0 default, 1 stop-on-error, 2 two-bit error counter
  int         m_phase [3];
  int         m_err   [3];
  int         m_instr [3];
  bit         m_mis   [3];
  bit         m_fv    [3];
  int         m_fph   [3];
  logic [6:0] m_fis   [3];
  logic [6:0] m_fexp  [3];
  bit         m_stop  [3];
  int         err_max [3] = '{255, 255, 3};
  bit         stop_on [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  ctrl_protocol_monitor dut_a (
    .clk(clk), .rst(rs_r), .enable(en_r), .sync(sy_r), .ctrl_bus(bus_r), .opcode(op_r), .zero(z_r),
    .phase(ph_o[0]), .expected(exp_o[0]), .mismatch(mis_o[0]), .err_count(err0),
    .first_err_valid(fv_o[0]), .first_err_phase(fph_o[0]), .first_err_is(fis_o[0]),
    .first_err_exp(fexp_o[0]), .instr_count(ic_o[0]), .stopped(st_o[0]));

  ctrl_protocol_monitor #(.ERR_W(8), .CNT_W(16), .STOP_ON_ERR(1'b1)) dut_b (
    .clk(clk), .rst(rs_r), .enable(en_r), .sync(sy_r), .ctrl_bus(bus_r), .opcode(op_r), .zero(z_r),
    .phase(ph_o[1]), .expected(exp_o[1]), .mismatch(mis_o[1]), .err_count(err1),
    .first_err_valid(fv_o[1]), .first_err_phase(fph_o[1]), .first_err_is(fis_o[1]),
    .first_err_exp(fexp_o[1]), .instr_count(ic_o[1]), .stopped(st_o[1]));

  ctrl_protocol_monitor #(.ERR_W(2), .CNT_W(16), .STOP_ON_ERR(1'b0)) dut_c (
    .clk(clk), .rst(rs_r), .enable(en_r), .sync(sy_r), .ctrl_bus(bus_r), .opcode(op_r), .zero(z_r),
    .phase(ph_o[2]), .expected(exp_o[2]), .mismatch(mis_o[2]), .err_count(err2),
    .first_err_valid(fv_o[2]), .first_err_phase(fph_o[2]), .first_err_is(fis_o[2]),
    .first_err_exp(fexp_o[2]), .instr_count(ic_o[2]), .stopped(st_o[2]));

  // Control word from the per-signal rules; phases 0..7 as integers
  function automatic logic [6:0] m_exp(input int ph, input int op, input bit z);
    bit alu = (op >= 2) && (op <= 5);
    bit mem_rd  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    bit load_ir = (ph == 2) || (ph == 3);
    bit halt    = (ph == 4) && (op == 0);
    bit inc_pc  = (ph == 4) || (ph == 6 && op == 1 && z) || (ph == 7 && op == 7);
    bit load_ac = (ph >= 6) && alu;
    bit load_pc = (ph >= 6) && (op == 7);
    bit mem_wr  = (ph == 7) && (op == 6);
    return {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
  endfunction

  function automatic logic [31:0] err_obs(input int i);
    if (i == 0) return 32'(err0);
    if (i == 1) return 32'(err1);
    return 32'(err2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_phase[i] = 0; m_err[i] = 0; m_instr[i] = 0; m_mis[i] = 1'b0; m_fv[i] = 1'b0;
      m_fph[i] = 0; m_fis[i] = 7'd0; m_fexp[i] = 7'd0; m_stop[i] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      logic [6:0] e;
      bit f;
      e = m_exp(m_phase[i], int'(op_r), z_r);
      if (rs_r) begin
        m_phase[i] = 0; m_err[i] = 0; m_instr[i] = 0; m_mis[i] = 1'b0; m_fv[i] = 1'b0;
        m_fph[i] = 0; m_fis[i] = 7'd0; m_fexp[i] = 7'd0; m_stop[i] = 1'b0;
      end else if (sy_r) begin
        m_phase[i] = 0;
        m_mis[i] = 1'b0;
      end else if (en_r && !m_stop[i]) begin
        f = (bus_r !== e);
        m_mis[i] = f;
        if (f) begin
          if (m_err[i] < err_max[i]) m_err[i]++;
          if (!m_fv[i]) begin
            m_fv[i] = 1'b1; m_fph[i] = m_phase[i]; m_fis[i] = bus_r; m_fexp[i] = e;
            if (stop_on[i]) m_stop[i] = 1'b1;
          end
        end
        if (!(f && stop_on[i])) begin
          if (m_phase[i] == 7 && m_instr[i] < 65535) m_instr[i]++;
          m_phase[i] = (m_phase[i] + 1) % 8;
        end
      end else begin
        m_mis[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("phase[%0d]", i), 32'(ph_o[i]), 32'(m_phase[i]));
      chk($sformatf("mismatch[%0d]", i), 32'(mis_o[i]), 32'(m_mis[i]));
      chk($sformatf("err_count[%0d]", i), err_obs(i), 32'(m_err[i]));
      chk($sformatf("instr_count[%0d]", i), 32'(ic_o[i]), 32'(m_instr[i]));
      chk($sformatf("first_err_valid[%0d]", i), 32'(fv_o[i]), 32'(m_fv[i]));
      chk($sformatf("first_err_phase[%0d]", i), 32'(fph_o[i]), 32'(m_fph[i]));
      chk($sformatf("first_err_is[%0d]", i), 32'(fis_o[i]), 32'(m_fis[i]));
      chk($sformatf("first_err_exp[%0d]", i), 32'(fexp_o[i]), 32'(m_fexp[i]));
      chk($sformatf("stopped[%0d]", i), 32'(st_o[i]), 32'(m_stop[i]));
    end
  endtask

  // One clock: drive on the falling edge, check the combinational word, then registered state
  task automatic step(input bit en, input bit sy, input bit rs, input logic [2:0] op,
                      input bit z, input logic [6:0] bus);
    @(negedge clk);
    en_r = en; sy_r = sy; rs_r = rs; op_r = op; z_r = z; bus_r = bus;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("expected[%0d]", i), 32'(exp_o[i]), 32'(m_exp(m_phase[i], int'(op), z)));
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic good(input logic [2:0] op, input bit z, input logic [6:0] mask);
    step(1'b1, 1'b0, 1'b0, op, z, m_exp(m_phase[0], int'(op), z) ^ mask);
  endtask

  initial begin
    logic [6:0] b;
    int held;
    // Power-up reset: outputs are unknown until the first reset edge
    rs_r = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check_all();

    // 1: two full ADD instructions with a correct bus
    for (int k = 0; k < 16; k++) good(ADD, 1'b0, 7'd0);
    chk("t1_instr", 32'(ic_o[0]), 32'd2);
    chk("t1_err", err_obs(0), 32'd0);

    // 2: SKZ with zero=1 but inc_pc missing in ALU_OP
    step(1'b1, 1'b0, 1'b1, SKZ, 1'b1, 7'd0);
    for (int k = 0; k < 6; k++) good(SKZ, 1'b1, 7'd0);
    step(1'b1, 1'b0, 1'b0, SKZ, 1'b1, 7'b0000000);
    chk("t2_mismatch", 32'(mis_o[0]), 32'd1);
    chk("t2_err", err_obs(0), 32'd1);
    chk("t2_fph", 32'(fph_o[0]), 32'd6);
    chk("t2_fis", 32'(fis_o[0]), 32'h00);
    chk("t2_fexp", 32'(fexp_o[0]), 32'h08);
    good(SKZ, 1'b1, 7'd0);

    // 3: HLT passes in OP_ADDR, then STO missing mem_wr in STORE
    for (int k = 0; k < 4; k++) good(HLT, 1'b0, 7'd0);
    step(1'b1, 1'b0, 1'b0, HLT, 1'b0, 7'b0011000);
    chk("t3_hlt_ok", 32'(mis_o[0]), 32'd0);
    good(HLT, 1'b0, 7'd0);
    good(HLT, 1'b0, 7'd0);
    step(1'b1, 1'b0, 1'b0, STO, 1'b0, 7'b0000000);
    chk("t3_err", err_obs(0), 32'd2);
    chk("t3_fph_kept", 32'(fph_o[0]), 32'd6);
    chk("t3_fexp_kept", 32'(fexp_o[0]), 32'h08);

    // 4: stop-on-error instance freezes at IDLE
    step(1'b1, 1'b0, 1'b1, ADD, 1'b0, 7'd0);
    for (int k = 0; k < 3; k++) good(ADD, 1'b0, 7'd0);
    good(ADD, 1'b0, 7'h01);
    for (int k = 0; k < 3; k++) good(ADD, 1'b0, 7'h40);
    chk("t4_stopped", 32'(st_o[1]), 32'd1);
    chk("t4_phase_held", 32'(ph_o[1]), 32'd3);
    chk("t4_err", err_obs(1), 32'd1);
    step(1'b1, 1'b0, 1'b1, ADD, 1'b0, 7'd0);
    chk("t4_rst_stopped", 32'(st_o[1]), 32'd0);

    // 5: two-bit error counter saturates; sync in OP_FETCH skips the compare
    for (int k = 0; k < 5; k++) good(ADD, 1'b0, 7'h01);
    chk("t5_err_sat", err_obs(2), 32'd3);
    chk("t5_phase5", 32'(ph_o[2]), 32'd5);
    step(1'b1, 1'b1, 1'b0, ADD, 1'b0, 7'h7f);
    chk("t5_sync_phase", 32'(ph_o[2]), 32'd0);
    chk("t5_sync_mis", 32'(mis_o[2]), 32'd0);
    chk("t5_sync_instr", 32'(ic_o[2]), 32'd0);

    // 6: disabled cycles ignore a bad bus; reset wins over sync
    good(ADD, 1'b0, 7'd0);
    held = m_phase[0];
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, ADD, 1'b0, 7'h55);
    chk("t6_phase_hold", 32'(ph_o[0]), 32'(held));
    step(1'b1, 1'b1, 1'b1, ADD, 1'b0, 7'h55);
    chk("t6_rst_err", err_obs(0), 32'd0);

    // Unknown bit on the bus is a failure
    b = m_exp(m_phase[0], int'(ADD), 1'b0);
    b[3] = 1'bx;
    step(1'b1, 1'b0, 1'b0, ADD, 1'b0, b);

    // Randomised traffic
    for (int k = 0; k < 500; k++) begin
      logic [2:0] op;
      bit z, en, sy, rs;
      logic [6:0] mask;
      op   = 3'($urandom_range(0, 7));
      z    = 1'($urandom_range(0, 1));
      en   = ($urandom_range(0, 99) < 85);
      sy   = ($urandom_range(0, 29) == 0);
      rs   = ($urandom_range(0, 59) == 0);
      mask = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      step(en, sy, rs, op, z, m_exp(m_phase[0], int'(op), z) ^ mask);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
